// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. ADD/SUB/AND/OR/XOR/NOT/SLT finish
//               one cycle after accept. MUL is an optional unsigned shift-add
//               multiplier that takes WIDTH cycles in BUSY. It is enabled by
//               the ALU_SEQ_MUL_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_last_step;

    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_res_cout;
    logic             w_res_ovf;

`ifdef ALU_SEQ_MUL_EN
    localparam int c_cnt_w = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*WIDTH-1:0] w_prod_nxt;

    assign w_is_mul    = (op == 3'b111);
    assign w_last_step = (r_state == S_BUSY) && (r_cnt == c_cnt_w'(WIDTH - 1));
    assign w_prod_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`else
    assign w_is_mul    = 1'b0;
    assign w_last_step = 1'b0;
`endif

    // A new op can be taken in IDLE, or in DONE when the result retires this cycle
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE with retire and accept chains straight into the next op
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle result; SUB is a + ~b + 1 so carry out means no borrow
    always_comb begin
        w_add      = {1'b0, a} + {1'b0, b};
        w_sub      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_res      = '0;
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
        case (op)
            3'b000: begin
                w_res      = w_add[WIDTH-1:0];
                w_res_cout = w_add[WIDTH];
                w_res_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                w_res      = w_sub[WIDTH-1:0];
                w_res_cout = w_sub[WIDTH];
                w_res_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  w_res = a & b;
            3'b011:  w_res = a | b;
            3'b100:  w_res = a ^ b;
            3'b101:  w_res = ~a;
            3'b110:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_res = '0;
        endcase
    end

    // Result registers: load on single-cycle accept or on the final multiply step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out  <= w_res;
            r_cout <= w_res_cout;
            r_ovf  <= w_res_ovf;
            r_zero <= (w_res == '0);
        end
`ifdef ALU_SEQ_MUL_EN
        else if (w_last_step) begin
            r_out  <= w_prod_nxt[WIDTH-1:0];
            r_cout <= |w_prod_nxt[2*WIDTH-1:WIDTH];
            r_ovf  <= 1'b0;
            r_zero <= (w_prod_nxt[WIDTH-1:0] == '0);
        end
`endif
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: one multiplier bit is consumed per BUSY cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_prod_nxt;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + c_cnt_w'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq at WIDTH=4. Stimulus pushes the
//               expected {out,cout,overflow,zero}, and a monitor pops and
//               compares on every retire. The MUL expectations follow the
//               ALU_SEQ_MUL_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;
    logic         overflow;
    logic         zero;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [6:0]   sb_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every retired result must match the oldest expected entry
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none at %0t",
                         {out, cout, overflow, zero}, $time);
            end else begin
                check("result", {25'd0, out, cout, overflow, zero}, {25'd0, sb_q.pop_front()});
            end
        end
    end

    // Present one op for exactly one accept edge, then scramble the operands
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic [2:0] top,
                         input logic [6:0] exp, input bit push);
        a        = ta;
        b        = tb_v;
        op       = top;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
        if (push) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        op       = 3'b010;
    endtask

    // Directed single-cycle vectors: a, b, op, {out, cout, overflow, zero}
    logic [3:0] va [11] = '{4'b1010, 4'b1010, 4'b0011, 4'b1100, 4'b0011, 4'b1100,
                            4'b1100, 4'b0101, 4'b1000, 4'b0111, 4'b0000};
    logic [3:0] vb [11] = '{4'b1010, 4'b1010, 4'b1111, 4'b1000, 4'b1111, 4'b1010,
                            4'b1010, 4'b0000, 4'b0111, 4'b0001, 4'b0001};
    logic [2:0] vop[11] = '{3'b000, 3'b001, 3'b001, 3'b110, 3'b100, 3'b010,
                            3'b011, 3'b101, 3'b110, 3'b000, 3'b001};
    logic [6:0] vex[11] = '{7'b0100_110, 7'b0000_101, 7'b0100_000, 7'b0000_001,
                            7'b1100_000, 7'b1000_000, 7'b1110_000, 7'b1010_000,
                            7'b0001_000, 7'b1000_010, 7'b1111_000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", {28'd0, out}, 32'd0);
        check("reset_flags", {29'd0, cout, overflow, zero}, 32'd0);
        rst_n = 1'b1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops, one per cycle
        for (int i = 0; i < 11; i++) begin
            issue(va[i], vb[i], vop[i], vex[i], 1'b1);
            check("latency1_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("idle_after_retire", {31'd0, out_valid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
        // MUL 12*8 = 96: low nibble 0, high nibble nonzero
        issue(4'b1100, 4'b1000, 3'b111, 7'b0000_101, 1'b1);
        check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        op       = 3'b000;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
            check("mul_busy_valid", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mul_latency", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        // MUL 3*5 = 15
        issue(4'b0011, 4'b0101, 3'b111, 7'b1111_000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("mul2_latency", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
`else
        issue(4'b1100, 4'b1000, 3'b111, 7'b0000_001, 1'b1);
        check("mul_off_latency", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
`endif

        // Backpressure: result held while the consumer stalls
        out_ready = 1'b0;
        issue(4'b0111, 4'b0001, 3'b000, 7'b1000_010, 1'b1);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stall_held", {25'd0, out, cout, overflow, zero}, {25'd0, 7'b1000_010});
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        issue(4'b0000, 4'b0001, 3'b001, 7'b1111_000, 1'b1);
        check("retire_accept_valid", {31'd0, out_valid}, 32'd1);
        check("retire_accept_out", {28'd0, out}, 32'hF);
        @(posedge clk);
        #1;

        // Reset while DONE discards the pending result
        out_ready = 1'b0;
        issue(4'b0001, 4'b0001, 3'b000, 7'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done_out", {25'd0, out, cout, overflow, zero}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("rst_done_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_SEQ_MUL_EN
        // Reset in the second BUSY cycle discards the multiply
        issue(4'b0011, 4'b0011, 3'b111, 7'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mul_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mul_out", {25'd0, out, cout, overflow, zero}, 32'd0);
        rst_n = 1'b1;
        check("rst_mul_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_mul_no_result", {31'd0, out_valid}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  WIDTH  result.
REQ-012 cout  output  1  carry flag.
REQ-013 overflow  output  1  signed overflow flag.
REQ-014 zero  output  1  out == 0.

Function
REQ-015 Handshake: operation accepted when in_valid && in_ready; result retired when out_valid && out_ready.
REQ-016 a, b and op are captured on accept; later changes are ignored until the next accept.
REQ-017 State machine IDLE, BUSY, DONE; IDLE->DONE on accept of a single-cycle op; IDLE->BUSY on accept of MUL; BUSY->DONE after the last MUL step; DONE->IDLE on retire without a new accept.
REQ-018 in_ready = (state==IDLE) || (state==DONE && out_ready); DONE plus retire plus accept in the same cycle goes directly to DONE (single-cycle op) or BUSY (MUL).
REQ-019 out_valid high only in DONE; out and flags held stable while out_valid && !out_ready.
REQ-020 Single-cycle ops: out_valid asserts the cycle after accept (latency 1); back-to-back throughput of 1 op/cycle when out_ready held high.
REQ-021 op 000 ADD: out = a+b mod 2^WIDTH; cout = carry out of MSB; overflow = signed overflow.
REQ-022 op 001 SUB: computed as a + ~b + 1; cout = carry out of MSB (1 = no borrow); overflow = signed overflow.
REQ-023 op 010 AND, 011 OR, 100 XOR, 101 NOT a: bitwise; cout=0, overflow=0.
REQ-024 op 110 SLT: out = 1 if signed a < signed b, else 0; cout=0, overflow=0.
REQ-025 op 111 MUL: unsigned shift-add, one bit per cycle, WIDTH cycles in BUSY; out = low WIDTH bits of product; cout = OR of high WIDTH bits; overflow=0; out_valid asserts WIDTH+1 cycles after accept.
REQ-026 zero is computed from out for every op, including MUL.
REQ-027 in_ready low throughout BUSY; in_valid during BUSY is not accepted.

Reset
REQ-028 rst_n low at a clock edge: state=IDLE, out=0, cout=0, overflow=0, zero=0, out_valid=0, MUL accumulator and counter cleared.
REQ-029 Reset during BUSY or DONE discards the operation; no out_valid is produced for it.
REQ-030 in_ready is 1 on the first cycle after reset deasserts.

Configuration
REQ-031 Macro ALU_SEQ_MUL_EN defined: op 111 is MUL per REQ-025, and BUSY state and multiplier datapath are present.
REQ-032 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic and BUSY unreachable; op 111 completes with latency 1 with out=0, cout=0, overflow=0, zero=1.

Verification (WIDTH=4, out_ready=1 unless stated)
REQ-033 ADD a=1010 b=1010 -> next cycle out=0100, cout=1, overflow=1, zero=0.
REQ-034 SUB a=1010 b=1010 -> out=0000, cout=1, overflow=0, zero=1; SUB a=0011 b=1111 -> out=0100, cout=0, overflow=0.
REQ-035 SLT a=1100 b=1000 -> out=0000, zero=1; XOR a=0011 b=1111 -> out=1100, cout=0.
REQ-036 MUL a=1100 b=1000 (macro on) -> in_ready low 4 cycles, out_valid at cycle 5, out=0000, cout=1, zero=1; macro off -> latency 1, out=0000, zero=1.
REQ-037 out_ready low for 3 cycles after ADD result -> out/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept same cycle, next result the following cycle.
REQ-038 rst_n low mid-MUL (cycle 2 of BUSY) -> next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1 once rst_n high.
